// File: rtl/fq_pkg.sv
// Shared types and sizing for the fetch queue.
package fq_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned PHT_ADDRESS = 9;
    localparam int unsigned GHR_SIZE    = 9;
    localparam int unsigned RAS_ADDRESS = 3;
    // Instruction entries; must be a power of 2 and at least 4.
    localparam int unsigned FQ_DEPTH    = 8;

    localparam int unsigned FQ_PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned FQ_CNT_W = FQ_PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [31:0]            instr;
        logic                   pred_taken;
        logic                   btb_hit;
        logic [XLEN-1:0]        pred_target;
        logic [PHT_ADDRESS-1:0] pht_index;
    } fq_slot_t;

    typedef struct packed {
        fq_slot_t               slot;
        logic [GHR_SIZE-1:0]    ghr;
        logic [RAS_ADDRESS-1:0] sp_snap;
        logic [2*XLEN-1:0]      ras_snap;
    } fq_entry_t;

    // A predicted-taken BTB hit in slot 1 redirects fetch, so slot 2 is dead.
    function automatic logic slot1_ends_bundle(fq_slot_t s);
        return s.btb_hit && s.pred_taken;
    endfunction

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Head/tail/count bookkeeping and handshake generation for the fetch queue.
module fq_ptr_ctrl
    import fq_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    input  logic                enq_valid_i,
    input  logic                enq_two_i,
    input  logic                deq_ready1_i,
    input  logic                deq_ready2_i,
    output logic                enq_ready_o,
    output logic                enq_fire_o,
    output logic                deq_valid1_o,
    output logic                deq_valid2_o,
    output logic [FQ_PTR_W-1:0] head_o,
    output logic [FQ_PTR_W-1:0] tail_o,
    output logic [FQ_CNT_W-1:0] count_o
);

    localparam logic [FQ_CNT_W-1:0] EnqLimit = FQ_CNT_W'(FQ_DEPTH - 2);
    localparam logic [FQ_CNT_W-1:0] CntOne   = FQ_CNT_W'(1);

    logic [FQ_PTR_W-1:0] head_q, head_d;
    logic [FQ_PTR_W-1:0] tail_q, tail_d;
    logic [FQ_CNT_W-1:0] count_q, count_d;
    logic [1:0]          push;
    logic [1:0]          pop;
    logic                take1;
    logic                take2;

    // Handshakes from registered count only, then pointer/count next-state.
    always_comb begin
        enq_ready_o  = (count_q <= EnqLimit);
        deq_valid1_o = (count_q != '0);
        deq_valid2_o = (count_q > CntOne);
        enq_fire_o   = enq_valid_i && enq_ready_o && !flush_i;

        take1 = deq_valid1_o && deq_ready1_i;
        take2 = take1 && deq_valid2_o && deq_ready2_i;

        push = 2'd0;
        if (enq_valid_i && enq_ready_o) begin
            push = enq_two_i ? 2'd2 : 2'd1;
        end
        pop = {1'b0, take1} + {1'b0, take2};

        head_d  = head_q + FQ_PTR_W'(pop);
        tail_d  = tail_q + FQ_PTR_W'(push);
        count_d = count_q + FQ_CNT_W'(push) - FQ_CNT_W'(pop);

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between PD and decode: 2-wide enqueue, 2-wide in-order dequeue.
module fetch_queue
    import fq_pkg::*;
(
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  fq_slot_t               enq_slot1,
    input  fq_slot_t               enq_slot2,
    input  logic [GHR_SIZE-1:0]    enq_ghr,
    input  logic [RAS_ADDRESS-1:0] enq_sp_snap,
    input  logic [2*XLEN-1:0]      enq_ras_snap,
    output logic                   deq_valid1,
    output logic                   deq_valid2,
    input  logic                   deq_ready1,
    input  logic                   deq_ready2,
    output fq_entry_t              deq_entry1,
    output fq_entry_t              deq_entry2,
    output logic [FQ_CNT_W-1:0]    fq_count
);

    fq_entry_t           mem_q [FQ_DEPTH];
    fq_entry_t           wr_entry1;
    fq_entry_t           wr_entry2;
    logic [FQ_PTR_W-1:0] head;
    logic [FQ_PTR_W-1:0] tail;
    logic [FQ_PTR_W-1:0] head_p1;
    logic [FQ_PTR_W-1:0] tail_p1;
    logic                enq_two;
    logic                enq_fire;

    fq_ptr_ctrl u_ptr_ctrl (
        .clk_i        (CLK),
        .reset_i      (reset),
        .flush_i      (flush),
        .enq_valid_i  (enq_valid),
        .enq_two_i    (enq_two),
        .deq_ready1_i (deq_ready1),
        .deq_ready2_i (deq_ready2),
        .enq_ready_o  (enq_ready),
        .enq_fire_o   (enq_fire),
        .deq_valid1_o (deq_valid1),
        .deq_valid2_o (deq_valid2),
        .head_o       (head),
        .tail_o       (tail),
        .count_o      (fq_count)
    );

    // Build per-instruction entries; bundle snapshots are replicated into both.
    always_comb begin
        enq_two            = !slot1_ends_bundle(enq_slot1);
        head_p1            = head + FQ_PTR_W'(1);
        tail_p1            = tail + FQ_PTR_W'(1);
        wr_entry1.slot     = enq_slot1;
        wr_entry1.ghr      = enq_ghr;
        wr_entry1.sp_snap  = enq_sp_snap;
        wr_entry1.ras_snap = enq_ras_snap;
        wr_entry2.slot     = enq_slot2;
        wr_entry2.ghr      = enq_ghr;
        wr_entry2.sp_snap  = enq_sp_snap;
        wr_entry2.ras_snap = enq_ras_snap;
    end

    // Storage: cleared on reset, written at tail / tail+1 on an accepted bundle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (enq_fire) begin
            mem_q[tail] <= wr_entry1;
            if (enq_two) begin
                mem_q[tail_p1] <= wr_entry2;
            end
        end
    end

    // Read ports; stale data behind a flush is qualified by deq_valid*.
    always_comb begin
        deq_entry1 = mem_q[head];
        deq_entry2 = mem_q[head_p1];
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, hand sequences, random vs queue model.
module tb_fetch_queue;
    import fq_pkg::*;

    logic                   CLK = 1'b0;
    logic                   reset, flush, enq_valid, enq_ready;
    fq_slot_t               enq_slot1, enq_slot2;
    logic [GHR_SIZE-1:0]    enq_ghr;
    logic [RAS_ADDRESS-1:0] enq_sp_snap;
    logic [2*XLEN-1:0]      enq_ras_snap;
    logic                   deq_valid1, deq_valid2, deq_ready1, deq_ready2;
    fq_entry_t              deq_entry1, deq_entry2;
    logic [FQ_CNT_W-1:0]    fq_count;

    int n_cmp = 0;
    int n_bad = 0;

    fq_entry_t model_q[$];
    bit        chk_zero;

    always #5 CLK = ~CLK;

    fetch_queue dut (
        .CLK          (CLK),
        .reset        (reset),
        .flush        (flush),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_slot1    (enq_slot1),
        .enq_slot2    (enq_slot2),
        .enq_ghr      (enq_ghr),
        .enq_sp_snap  (enq_sp_snap),
        .enq_ras_snap (enq_ras_snap),
        .deq_valid1   (deq_valid1),
        .deq_valid2   (deq_valid2),
        .deq_ready1   (deq_ready1),
        .deq_ready2   (deq_ready2),
        .deq_entry1   (deq_entry1),
        .deq_entry2   (deq_entry2),
        .fq_count     (fq_count)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fq_slot_t make_slot(input logic [31:0] pc, input logic taken,
                                           input logic hit, input logic [31:0] tgt);
        fq_slot_t s;
        s.pc          = pc;
        s.instr       = (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
        s.pred_taken  = taken;
        s.btb_hit     = hit;
        s.pred_target = tgt;
        s.pht_index   = pc[10:2];
        return s;
    endfunction

    task automatic drive_bundle(input logic [31:0] pc, input logic taken, input logic hit,
                                input logic [GHR_SIZE-1:0] ghr, input logic [RAS_ADDRESS-1:0] sp,
                                input logic [2*XLEN-1:0] ras);
        enq_slot1    = make_slot(pc, taken, hit, 32'h100);
        enq_slot2    = make_slot(pc + 32'd4, 1'b0, 1'b0, pc + 32'd64);
        enq_ghr      = ghr;
        enq_sp_snap  = sp;
        enq_ras_snap = ras;
    endtask

    // Deterministic snapshot values for directed bundles, keyed by pc.
    task automatic drive_pc(input logic [31:0] pc, input logic taken);
        drive_bundle(pc, taken, taken, pc[10:2] ^ 9'h155, pc[5:3],
                     {pc ^ 32'hDEAD_BEEF, ~pc});
    endtask

    // Compare outputs against the model, then advance one clock and update the model.
    task automatic tick();
        int        sz;
        int        npop;
        bit        accept;
        fq_entry_t e1, e2;
        sz = model_q.size();
        check("fq_count", fq_count, sz);
        check("enq_ready", enq_ready, sz <= FQ_DEPTH - 2);
        check("deq_valid1", deq_valid1, sz >= 1);
        check("deq_valid2", deq_valid2, sz >= 2);
        if (sz >= 1) check("deq_entry1", deq_entry1, model_q[0]);
        if (sz >= 2) check("deq_entry2", deq_entry2, model_q[1]);
        if (chk_zero) begin
            check("rst_entry1_zero", deq_entry1, 0);
            check("rst_entry2_zero", deq_entry2, 0);
        end
        accept = enq_valid && (sz <= FQ_DEPTH - 2);
        npop = 0;
        if (sz >= 1 && deq_ready1) npop = (sz >= 2 && deq_ready2) ? 2 : 1;
        e1.slot = enq_slot1; e1.ghr = enq_ghr; e1.sp_snap = enq_sp_snap; e1.ras_snap = enq_ras_snap;
        e2.slot = enq_slot2; e2.ghr = enq_ghr; e2.sp_snap = enq_sp_snap; e2.ras_snap = enq_ras_snap;
        @(posedge CLK);
        chk_zero = reset;
        if (reset || flush) begin
            model_q.delete();
        end else begin
            repeat (npop) void'(model_q.pop_front());
            if (accept) begin
                model_q.push_back(e1);
                if (!(enq_slot1.btb_hit && enq_slot1.pred_taken)) model_q.push_back(e2);
            end
        end
        #1;
    endtask

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic        tk;
        logic        r1;
        logic        r2;
        logic        fl;
        int          exp_cnt;
        logic        exp_rdy;
        logic        exp_v1;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[18];

    initial begin
        vt[0]  = '{1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h000};
        vt[1]  = '{1'b1, 32'h008, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1, 32'h000};
        vt[2]  = '{1'b1, 32'h010, 1'b0, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b1, 32'h000};
        vt[3]  = '{1'b1, 32'h018, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 32'h000};
        vt[4]  = '{1'b1, 32'h020, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 32'h000};
        vt[5]  = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b0, 6, 1'b1, 1'b1, 32'h008};
        vt[6]  = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 1'b0, 6, 1'b1, 1'b1, 32'h008};
        vt[7]  = '{1'b1, 32'h020, 1'b1, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b1, 32'h008};
        vt[8]  = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b1, 32'h010};
        vt[9]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b1, 32'h010};
        vt[10] = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b1, 32'h014};
        vt[11] = '{1'b1, 32'h180, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h000};
        vt[12] = '{1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h200};
        vt[13] = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h000};
        vt[14] = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h300};
        vt[15] = '{1'b1, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1, 32'h300};
        vt[16] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b1, 32'h300};
        vt[17] = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h308};

        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0;
        deq_ready1 = 1'b0; deq_ready2 = 1'b0;
        drive_pc(32'h0, 1'b0);
        chk_zero = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        chk_zero = 1'b1;
        check("rst_count", fq_count, 0);
        check("rst_enq_ready", enq_ready, 1);
        check("rst_deq_valid1", deq_valid1, 0);
        check("rst_deq_valid2", deq_valid2, 0);

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            enq_valid  = vt[i].ev;
            deq_ready1 = vt[i].r1;
            deq_ready2 = vt[i].r2;
            flush      = vt[i].fl;
            drive_pc(vt[i].pc, vt[i].tk);
            tick();
            check($sformatf("vec%0d_count", i), fq_count, vt[i].exp_cnt);
            check($sformatf("vec%0d_enq_ready", i), enq_ready, vt[i].exp_rdy);
            check($sformatf("vec%0d_deq_valid1", i), deq_valid1, vt[i].exp_v1);
            if (vt[i].exp_v1) check($sformatf("vec%0d_head_pc", i), deq_entry1.slot.pc, vt[i].exp_pc);
        end
        flush = 1'b0;

        // Steady state: 2 in / 2 out per cycle through several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            enq_valid = 1'b1; deq_ready1 = 1'b1; deq_ready2 = 1'b1;
            drive_pc(32'h400 + 32'(8 * i), 1'b0);
            tick();
            check($sformatf("steady%0d_count", i), fq_count, 2);
            check($sformatf("steady%0d_head_pc", i), deq_entry1.slot.pc, 32'h400 + 32'(8 * i));
        end

        // Randomized traffic with occasional flush and mid-operation reset.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(299) == 0);
            flush      = ($urandom_range(39) == 0);
            enq_valid  = ($urandom_range(99) < 70);
            deq_ready1 = ($urandom_range(99) < 60);
            deq_ready2 = ($urandom_range(99) < 60);
            drive_bundle({$urandom_range(32'h3FFF_FFFF), 2'b00}, ($urandom_range(3) == 0),
                         ($urandom_range(3) == 0), GHR_SIZE'($urandom),
                         RAS_ADDRESS'($urandom), {$urandom, $urandom});
            tick();
        end

        // Drain.
        reset = 1'b0; flush = 1'b0; enq_valid = 1'b0;
        deq_ready1 = 1'b1; deq_ready2 = 1'b1;
        repeat (6) tick();
        check("drain_count", fq_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer directly downstream of the predict/fetch (PD) stage.
- Accepts one 2-wide fetch bundle per cycle: the PC pair, both instruction words from the I-cache, and the per-slot prediction metadata from PD.
- Drops slot 2 when slot 1 is a predicted-taken BTB hit.
- Presents up to 2 in-order instructions per cycle to decode with a per-slot ready handshake.
- Flushed on mispredict / restore.

Parameters:
- XLEN, 32, datapath / PC width
- PHT_ADDRESS, 9, PHT index width carried per instruction
- GHR_SIZE, 9, GHR snapshot width
- RAS_ADDRESS, 3, RAS stack-pointer snapshot width
- DEPTH, 8, instruction entries; power of 2, minimum 4

Ports:
- CLK  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- flush  in  1  mispredict/restore; empties the queue
- enq_valid  in  1  PD bundle valid
- enq_ready  out  1  queue can take a full bundle
- enq_slot1  in  fq_slot_t  slot 1 fields: pc, instr, pred_taken, btb_hit, pred_target, pht_index
- enq_slot2  in  fq_slot_t  slot 2 fields; pc = slot1.pc+4 is supplied by PD
- enq_ghr  in  GHR_SIZE  prev_ghr snapshot for the bundle
- enq_sp_snap  in  RAS_ADDRESS  RAS sp snapshot
- enq_ras_snap  in  2*XLEN  RAS top-entries snapshot
- deq_valid1  out  1  head entry valid
- deq_valid2  out  1  head+1 entry valid
- deq_ready1  in  1  decode takes head
- deq_ready2  in  1  decode takes head+1; honoured only with deq_ready1
- deq_entry1  out  fq_entry_t  head entry: slot fields + ghr/sp/ras snapshot
- deq_entry2  out  fq_entry_t  head+1 entry
- fq_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular array of DEPTH fq_entry_t with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- Bundle metadata (ghr, sp, ras) is copied into each instruction entry enqueued from that bundle.
- Enqueue:
  - enq_ready = (count <= DEPTH-2), computed from the registered count only; no same-cycle dequeue credit.
  - On enq_valid && enq_ready: write slot1 at tail.
  - Write slot2 at tail+1 unless (slot1.btb_hit && slot1.pred_taken).
  - tail advances by 1 or 2 accordingly.
- Dequeue:
  - deq_valid1 = (count >= 1); deq_valid2 = (count >= 2).
  - deq_entry1/2 are read combinationally from the array at head / head+1.
  - pop = (deq_valid1 && deq_ready1) + (deq_valid1 && deq_ready1 && deq_valid2 && deq_ready2).
  - head advances by pop.
- Count: count_next = count + push - pop, where push ∈ {0,1,2} and pop ∈ {0,1,2}. Simultaneous push and pop are legal at any occupancy that enq_ready permits.
- Latency: an entry written in cycle N is visible at the dequeue side in N+1. There is no enqueue→dequeue bypass.
- Flush:
  - Next cycle: head = tail = count = 0; deq_valid* = 0; enq_ready = 1.
  - A push or pop in the flush cycle is discarded.
  - Flush has priority over enqueue and dequeue.
- Reset:
  - Same effect as flush; reset has priority over flush.
  - Storage is also cleared to 0, so deq_entry1/2 = 0 and fq_count = 0 after reset.
  - Mid-operation reset discards all contents.
- Boundary cases:
  - Full (count = DEPTH): enq_ready = 0 even if decode pops this cycle.
  - count = DEPTH-1: enq_ready = 0, because the bundle might carry 2 instructions.
  - Empty: deq_valid1 = 0, and any ready is ignored.
  - Pointer wrap at DEPTH-1 → 0 applies to both tail+1 and head+1.
- No X propagation: stale entries read after a flush are masked by the deq_valid* signals.

Decomposition:
- Package fq_pkg holds:
  - fq_slot_t, packed: pc[XLEN], instr[32], pred_taken, btb_hit, pred_target[XLEN], pht_index[PHT_ADDRESS] (107 bits at defaults).
  - fq_entry_t, packed: fq_slot_t + ghr[GHR_SIZE] + sp_snap[RAS_ADDRESS] + ras_snap[2*XLEN].
  - Localparams FQ_PTR_W = $clog2(DEPTH) and FQ_CNT_W = FQ_PTR_W+1.
- One natural sub-module, fq_ptr_ctrl: owns head/tail/count, the push/pop arithmetic, enq_ready and deq_valid*.
- The storage array lives in fetch_queue.

Test Plan:
- Reset, then 4 bundles at pc 0x0, 0x8, 0x10, 0x18 with no taken branches and deq_ready* = 0 → count 8, enq_ready = 0; deq order gives pcs 0x0 through 0x1C.
- Bundle with slot1 btb_hit = 1, pred_taken = 1, pred_target = 0x100 → count +1 only; the next bundle at 0x100 lands at head+1.
- count = 7, enq_valid = 1 with deq_ready1 = deq_ready2 = 1 → no enqueue; count = 5 next cycle; enq_ready = 1.
- Steady state, 2 in / 2 out per cycle for 20 cycles across pointer wrap → count stays constant; pcs strictly +4 sequential; ghr/sp/ras snapshots match their bundles.
- count = 3, flush together with enq_valid and deq_ready1 → next cycle count = 0, deq_valid1 = 0, enq_ready = 1; the discarded bundle never appears.
- deq_ready2 = 1 with deq_ready1 = 0 at count = 4 → no pop; count stays 4.
